branch_cond_unit: RTL and testbench

Consumes the 4-bit N/Z/V/C condition codes produced by `mini_alu` and decides SPARC Bicc branches. It holds the architectural integer condition-code register, evaluates the 16 Bicc conditions when a branch issues, and tracks the single delay slot that follows it, including the annul (`a`) bit. It sits between decode and the fetch/PC logic. `taken` selects the branch target. `annul_slot` squashes the delay-slot instruction.

---
 rtl/cc_pkg.sv | 24 ++
 rtl/cond_eval.sv | 20 ++
 rtl/branch_cond_unit.sv | 57 +++++
 tb/tb_branch_cond_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// cc_pkg: Bicc condition encodings, flag bit positions and branch FSM states
package cc_pkg;
  localparam logic [3:0] COND_BN   = 4'b0000;
  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BLE  = 4'b0010;
  localparam logic [3:0] COND_BL   = 4'b0011;
  localparam logic [3:0] COND_BLEU = 4'b0100;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;
  localparam logic [3:0] COND_BNE  = 4'b1001;
  localparam logic [3:0] COND_BG   = 4'b1010;
  localparam logic [3:0] COND_BGE  = 4'b1011;
  localparam logic [3:0] COND_BGU  = 4'b1100;
  localparam logic [3:0] COND_BCC  = 4'b1101;
  localparam logic [3:0] COND_BPOS = 4'b1110;
  localparam logic [3:0] COND_BVC  = 4'b1111;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
  typedef enum logic [1:0] {IDLE, SLOT, ANNUL} state_t;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational Bicc condition evaluator over {N,Z,V,C}
module cond_eval
  import cc_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [3:0] i_cond,
  output logic       o_result
);
  logic w_n, w_z, w_v, w_c;
  logic [7:0] w_tab;
  always_comb begin
    w_n = i_flags[FLAG_N];
    w_z = i_flags[FLAG_Z];
    w_v = i_flags[FLAG_V];
    w_c = i_flags[FLAG_C];
    // cond[3] inverts the base test selected by cond[2:0]
    w_tab = {w_v, w_n, w_c, w_c | w_z, w_n ^ w_v, w_z | (w_n ^ w_v), w_z, 1'b0};
    o_result = i_cond[3] ^ w_tab[i_cond[2:0]];
  end
endmodule

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: SPARC Bicc resolution, cc register and delay-slot tracking; CC_FWD_EN forwards same-edge flags
module branch_cond_unit
  import cc_pkg::*;
(
  input  logic       Clk,
  input  logic       Clr,
  input  logic       adv,
  input  logic [3:0] flags_in,
  input  logic       cc_we,
  input  logic       is_branch,
  input  logic [3:0] cond,
  input  logic       annul_bit,
  output logic [3:0] cc,
  output logic       taken,
  output logic       annul_slot,
  output logic       in_slot,
  output logic       dcti_err
);
  state_t r_state;
  state_t w_next;
  logic [3:0] r_cc;
  logic [3:0] w_eval_flags;
  logic r_taken, r_err, w_result, w_br;
  always_comb begin
`ifdef CC_FWD_EN
    w_eval_flags = cc_we ? flags_in : r_cc;
`else
    w_eval_flags = r_cc;
`endif
    w_br = (r_state == IDLE) & is_branch;
    // BA with a=1 annuls its slot even though taken
    w_next = !w_br ? IDLE : (annul_bit & (~w_result | (cond == COND_BA))) ? ANNUL : SLOT;
  end
  cond_eval u_eval (
    .i_flags (w_eval_flags),
    .i_cond  (cond),
    .o_result(w_result)
  );
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state <= IDLE;
      r_cc    <= 4'b0000;
      r_taken <= 1'b0;
      r_err   <= 1'b0;
    end else if (adv) begin
      r_state <= w_next;
      r_taken <= w_br & w_result;
      if (cc_we && r_state != ANNUL) r_cc <= flags_in;
      if (is_branch && r_state == SLOT) r_err <= 1'b1;
    end
  end
  assign cc         = r_cc;
  assign taken      = r_taken;
  assign annul_slot = r_state == ANNUL;
  assign in_slot    = r_state != IDLE;
  assign dcti_err   = r_err;
endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: directed Bicc vectors with queued expectations checked by a monitor
module tb_branch_cond_unit;
  logic       Clk = 1'b0;
  logic       Clr = 1'b1;
  logic       adv = 1'b0;
  logic [3:0] flags_in = 4'b0000;
  logic       cc_we = 1'b0;
  logic       is_branch = 1'b0;
  logic [3:0] cond = 4'b0000;
  logic       annul_bit = 1'b0;
  logic [3:0] cc;
  logic       taken, annul_slot, in_slot, dcti_err;
`ifdef CC_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif
  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int n_tests = 0;
  int n_fail = 0;
  always #5 Clk = ~Clk;
  branch_cond_unit dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .adv       (adv),
    .flags_in  (flags_in),
    .cc_we     (cc_we),
    .is_branch (is_branch),
    .cond      (cond),
    .annul_bit (annul_bit),
    .cc        (cc),
    .taken     (taken),
    .annul_slot(annul_slot),
    .in_slot   (in_slot),
    .dcti_err  (dcti_err)
  );
  function automatic logic [7:0] ex(input logic [3:0] c, input logic t, input logic a,
                                    input logic s, input logic e);
    return {c, t, a, s, e};
  endfunction
  always @(negedge Clk) begin
    while (q.size() > 0) begin
      m_e = q.pop_front();
      n_tests++;
      if ({cc, taken, annul_slot, in_slot, dcti_err} !== m_e.v) begin
        n_fail++;
        $display("FAIL %s: got {cc,taken,annul,in_slot,err}=%b required %b", m_e.name,
                 {cc, taken, annul_slot, in_slot, dcti_err}, m_e.v);
      end
    end
  end
  task automatic step(input string nm, input logic a_adv, input logic a_we, input logic [3:0] a_fl,
                      input logic a_br, input logic [3:0] a_cond, input logic a_an,
                      input logic [7:0] e);
    adv = a_adv;
    cc_we = a_we;
    flags_in = a_fl;
    is_branch = a_br;
    cond = a_cond;
    annul_bit = a_an;
    @(posedge Clk);
    #1 q.push_back('{nm, e});
  endtask
  initial begin
    @(posedge Clk);
    #1 q.push_back('{"reset", ex(4'h0, 0, 0, 0, 0)});
    Clr = 1'b0;
    step("ccw_z",      1, 1, 4'b0100, 0, 4'b0000, 0, ex(4'h4, 0, 0, 0, 0));
    step("be_taken",   1, 0, 4'b0000, 1, 4'b0001, 0, ex(4'h4, 1, 0, 1, 0));
    step("be_slot",    1, 0, 4'b0000, 0, 4'b0000, 0, ex(4'h4, 0, 0, 0, 0));
    step("bne_a",      1, 0, 4'b0000, 1, 4'b1001, 1, ex(4'h4, 0, 1, 1, 0));
    step("annul_ccwe", 1, 1, 4'b1000, 0, 4'b0000, 0, ex(4'h4, 0, 0, 0, 0));
    step("ba_a",       1, 0, 4'b0000, 1, 4'b1000, 1, ex(4'h4, 1, 1, 1, 0));
    step("annul_br",   1, 1, 4'b0001, 1, 4'b1000, 0, ex(4'h4, 0, 0, 0, 0));
    step("bn_a",       1, 0, 4'b0000, 1, 4'b0000, 1, ex(4'h4, 0, 1, 1, 0));
    step("bn_slot",    1, 0, 4'b0000, 0, 4'b0000, 0, ex(4'h4, 0, 0, 0, 0));
    step("be_stall",   1, 0, 4'b0000, 1, 4'b0001, 0, ex(4'h4, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      step("hold",     0, 1, 4'b0001, 1, 4'b1000, 0, ex(4'h4, 1, 0, 1, 0));
    step("dcti",       1, 0, 4'b0000, 1, 4'b1000, 0, ex(4'h4, 0, 0, 0, 1));
    step("err_sticky", 1, 0, 4'b0000, 0, 4'b0000, 0, ex(4'h4, 0, 0, 0, 1));
    step("b2b_be",     1, 0, 4'b0000, 1, 4'b0001, 0, ex(4'h4, 1, 0, 1, 1));
    step("b2b_slot",   1, 0, 4'b0000, 0, 4'b0000, 0, ex(4'h4, 0, 0, 0, 1));
    step("b2b_bne",    1, 0, 4'b0000, 1, 4'b1001, 0, ex(4'h4, 0, 0, 1, 1));
    step("b2b_slot2",  1, 0, 4'b0000, 0, 4'b0000, 0, ex(4'h4, 0, 0, 0, 1));
    step("ccw_nv",     1, 1, 4'b1010, 0, 4'b0000, 0, ex(4'ha, 0, 0, 0, 1));
    step("bg",         1, 0, 4'b0000, 1, 4'b1010, 0, ex(4'ha, 1, 0, 1, 1));
    step("bg_slot",    1, 0, 4'b0000, 0, 4'b0000, 0, ex(4'ha, 0, 0, 0, 1));
    step("bl_a",       1, 0, 4'b0000, 1, 4'b0011, 1, ex(4'ha, 0, 1, 1, 1));
    step("bl_slot",    1, 0, 4'b0000, 0, 4'b0000, 0, ex(4'ha, 0, 0, 0, 1));
    step("ccw_c",      1, 1, 4'b0001, 0, 4'b0000, 0, ex(4'h1, 0, 0, 0, 1));
    step("bleu",       1, 0, 4'b0000, 1, 4'b0100, 0, ex(4'h1, 1, 0, 1, 1));
    step("bleu_slot",  1, 0, 4'b0000, 0, 4'b0000, 0, ex(4'h1, 0, 0, 0, 1));
    step("be_nt",      1, 0, 4'b0000, 1, 4'b0001, 0, ex(4'h1, 0, 0, 1, 1));
    adv = 1'b0;
    is_branch = 1'b0;
    @(posedge Clk);
    #2 Clr = 1'b1;
    #1 q.push_back('{"clr_async", ex(4'h0, 0, 0, 0, 0)});
    #1 Clr = 1'b0;
    step("fwd_be",     1, 1, 4'b0100, 1, 4'b0001, 0, ex(4'h4, FWD, 0, 1, 0));
    step("fwd_slot",   1, 0, 4'b0000, 0, 4'b0000, 0, ex(4'h4, 0, 0, 0, 0));
    @(negedge Clk);
    @(negedge Clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
